// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one toggle-handshake 16-bit memory port between the
// ioctl download writer and two byte-wide read requesters (A = main CPU,
// B = second CPU). Downloads always win; A and B alternate when both wait.
// Optional build macro ROM_WORD_CACHE_EN adds a one-word read cache per
// requester so repeated reads of the same 16-bit word skip the memory port.
module rom_port_arbiter #(
  parameter int RD_AW = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_downl,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  input  logic             a_rd,
  input  logic [RD_AW-1:0] a_addr,
  output logic [7:0]       a_data,
  output logic             a_valid,
  input  logic             b_rd,
  input  logic [RD_AW-1:0] b_addr,
  output logic [7:0]       b_data,
  output logic             b_valid,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             mem_we,
  output logic [21:0]      mem_addr,
  output logic [1:0]       mem_ds,
  output logic [15:0]      mem_din,
  input  logic [15:0]      mem_dout,
  output logic             dl_ovf
);

  typedef enum logic [1:0] {IDLE, DL_WAIT, RD_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_wr_q, r_downl_q;
  logic             w_wr_rise, w_downl_rise;
  logic             r_dl_pend, r_dl_ovf;
  logic [22:0]      r_dl_addr;
  logic [7:0]       r_dl_data;
  logic             r_a_pend, r_b_pend;
  logic [RD_AW-1:0] r_a_addr, r_b_addr;
  logic             r_prio_b, r_cur_b, r_cur_lsb;
  logic             r_mem_req, r_mem_we;
  logic [21:0]      r_mem_addr;
  logic [1:0]       r_mem_ds;
  logic [15:0]      r_mem_din;
  logic [7:0]       r_a_data, r_b_data;
  logic             r_a_valid, r_b_valid;
  logic             w_a_req, w_b_req, w_a_hit, w_b_hit;
  logic             w_iss_dl, w_iss_a, w_iss_b, w_done, w_rd_done;
  logic [RD_AW-1:0] w_rd_addr;
  logic [7:0]       w_rd_byte;

  assign w_wr_rise    = ioctl_wr & ~r_wr_q;
  assign w_downl_rise = ioctl_downl & ~r_downl_q;
  // Read strobes are dropped outright while a download owns the memory.
  assign w_a_req      = a_rd & ~ioctl_downl;
  assign w_b_req      = b_rd & ~ioctl_downl;
  assign w_rd_addr    = w_iss_b ? r_b_addr : r_a_addr;
  assign w_rd_done    = w_done & (r_state == RD_WAIT);
  assign w_rd_byte    = r_cur_lsb ? mem_dout[15:8] : mem_dout[7:0];

  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_ds   = r_mem_ds;
  assign mem_din  = r_mem_din;
  assign a_data   = r_a_data;
  assign a_valid  = r_a_valid;
  assign b_data   = r_b_data;
  assign b_valid  = r_b_valid;
  assign dl_ovf   = r_dl_ovf;

  // Previous-cycle copies of the strobes for edge detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_q    <= 1'b0;
      r_downl_q <= 1'b0;
    end else begin
      r_wr_q    <= ioctl_wr;
      r_downl_q <= ioctl_downl;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and issue decisions: download first, then round-robin A/B.
  // Reads are held back on the cycle a download starts, since that edge
  // flushes every pending read.
  always_comb begin
    w_state_nxt = r_state;
    w_iss_dl    = 1'b0;
    w_iss_a     = 1'b0;
    w_iss_b     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_dl_pend) begin
          w_iss_dl    = 1'b1;
          w_state_nxt = DL_WAIT;
        end else if (!w_downl_rise && r_a_pend && (!r_b_pend || !r_prio_b)) begin
          w_iss_a     = 1'b1;
          w_state_nxt = RD_WAIT;
        end else if (!w_downl_rise && r_b_pend) begin
          w_iss_b     = 1'b1;
          w_state_nxt = RD_WAIT;
        end
      end
      DL_WAIT, RD_WAIT: begin
        if (mem_ack == r_mem_req) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Download byte capture; a second byte before the first is issued is lost
  // and flagged. A byte landing on the issue edge refills the slot cleanly.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_pend <= 1'b0;
      r_dl_addr <= '0;
      r_dl_data <= '0;
      r_dl_ovf  <= 1'b0;
    end else if (w_wr_rise) begin
      if (r_dl_pend && !w_iss_dl) begin
        r_dl_ovf <= 1'b1;
      end else begin
        r_dl_pend <= 1'b1;
        r_dl_addr <= ioctl_addr[22:0];
        r_dl_data <= ioctl_dout;
      end
    end else if (w_iss_dl) begin
      r_dl_pend <= 1'b0;
    end
  end

  // Read request capture: a newer strobe replaces the address of an unserved
  // one; a strobe on or after the issue edge becomes a fresh request.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_a_pend <= 1'b0;
      r_a_addr <= '0;
      r_b_pend <= 1'b0;
      r_b_addr <= '0;
    end else begin
      if (w_downl_rise)                r_a_pend <= 1'b0;
      else if (w_a_req && !w_a_hit) begin
        r_a_pend <= 1'b1;
        r_a_addr <= a_addr;
      end else if (w_iss_a || w_a_hit) r_a_pend <= 1'b0;
      if (w_downl_rise)                r_b_pend <= 1'b0;
      else if (w_b_req && !w_b_hit) begin
        r_b_pend <= 1'b1;
        r_b_addr <= b_addr;
      end else if (w_iss_b || w_b_hit) r_b_pend <= 1'b0;
    end
  end

  // Memory port drive: request toggle and payload move together on issue.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_ds   <= '0;
      r_mem_din  <= '0;
      r_cur_b    <= 1'b0;
      r_cur_lsb  <= 1'b0;
      r_prio_b   <= 1'b0;
    end else if (w_iss_dl) begin
      r_mem_req  <= ~r_mem_req;
      r_mem_we   <= 1'b1;
      r_mem_addr <= r_dl_addr[22:1];
      r_mem_ds   <= {r_dl_addr[0], ~r_dl_addr[0]};
      r_mem_din  <= {r_dl_data, r_dl_data};
    end else if (w_iss_a || w_iss_b) begin
      r_mem_req  <= ~r_mem_req;
      r_mem_we   <= 1'b0;
      r_mem_addr <= 22'(w_rd_addr >> 1);
      r_mem_ds   <= 2'b11;
      r_cur_b    <= w_iss_b;
      r_cur_lsb  <= w_rd_addr[0];
      r_prio_b   <= w_iss_a;
    end
  end

`ifdef ROM_WORD_CACHE_EN
  logic             r_a_cv, r_b_cv;
  logic [RD_AW-2:0] r_a_ctag, r_b_ctag;
  logic [15:0]      r_a_cdat, r_b_cdat;
  logic [7:0]       w_a_hit_byte, w_b_hit_byte;

  // A hit is not taken while that requester's own read is in flight, so the
  // completion pulse and the hit pulse can never collide.
  assign w_a_hit = w_a_req & r_a_cv & (r_a_ctag == a_addr[RD_AW-1:1]) &
                   ~((r_state == RD_WAIT) & ~r_cur_b);
  assign w_b_hit = w_b_req & r_b_cv & (r_b_ctag == b_addr[RD_AW-1:1]) &
                   ~((r_state == RD_WAIT) & r_cur_b);
  assign w_a_hit_byte = a_addr[0] ? r_a_cdat[15:8] : r_a_cdat[7:0];
  assign w_b_hit_byte = b_addr[0] ? r_b_cdat[15:8] : r_b_cdat[7:0];

  // Word cache fill on read completion; a new download invalidates both.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_a_cv   <= 1'b0;
      r_b_cv   <= 1'b0;
      r_a_ctag <= '0;
      r_b_ctag <= '0;
      r_a_cdat <= '0;
      r_b_cdat <= '0;
    end else if (w_downl_rise) begin
      r_a_cv <= 1'b0;
      r_b_cv <= 1'b0;
    end else if (w_rd_done) begin
      if (r_cur_b) begin
        r_b_cv   <= 1'b1;
        r_b_ctag <= r_mem_addr[RD_AW-2:0];
        r_b_cdat <= mem_dout;
      end else begin
        r_a_cv   <= 1'b1;
        r_a_ctag <= r_mem_addr[RD_AW-2:0];
        r_a_cdat <= mem_dout;
      end
    end
  end
`else
  assign w_a_hit = 1'b0;
  assign w_b_hit = 1'b0;
`endif

  // Read responses: byte select on completion (or cache hit), one-cycle valid.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
    end else begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      if (w_rd_done && !r_cur_b) begin
        r_a_data  <= w_rd_byte;
        r_a_valid <= 1'b1;
      end
      if (w_rd_done && r_cur_b) begin
        r_b_data  <= w_rd_byte;
        r_b_valid <= 1'b1;
      end
`ifdef ROM_WORD_CACHE_EN
      if (w_a_hit) begin
        r_a_data  <= w_a_hit_byte;
        r_a_valid <= 1'b1;
      end
      if (w_b_hit) begin
        r_b_data  <= w_b_hit_byte;
        r_b_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a latency-modelled toggle memory
// and scoreboards for memory transactions and per-requester read data.
module tb_rom_port_arbiter;
  localparam int RD_AW = 16;
  localparam int LAT   = 6;

  logic             clk_sys = 1'b0, reset = 1'b0;
  logic             ioctl_downl = 1'b0, ioctl_wr = 1'b0;
  logic [24:0]      ioctl_addr = '0;
  logic [7:0]       ioctl_dout = '0;
  logic             a_rd = 1'b0, b_rd = 1'b0;
  logic [RD_AW-1:0] a_addr = '0, b_addr = '0;
  logic [7:0]       a_data, b_data;
  logic             a_valid, b_valid;
  logic             mem_req, mem_we, dl_ovf;
  logic             mem_ack = 1'b0;
  logic [21:0]      mem_addr;
  logic [1:0]       mem_ds;
  logic [15:0]      mem_din;
  logic [15:0]      mem_dout = '0;

  rom_port_arbiter #(.RD_AW(RD_AW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .a_rd(a_rd), .a_addr(a_addr), .a_data(a_data), .a_valid(a_valid),
    .b_rd(b_rd), .b_addr(b_addr), .b_data(b_data), .b_valid(b_valid),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ds(mem_ds), .mem_din(mem_din), .mem_dout(mem_dout), .dl_ovf(dl_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [1:0]  ds;
    logic [15:0] din;
  } mtx_t;

  mtx_t       qm[$];
  logic [7:0] qa[$], qb[$];
  int         checks = 0, errors = 0, n_tog = 0;
  logic [15:0] mem [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic push_rd(input logic [21:0] waddr);
    mtx_t t;
    t = '{we: 1'b0, addr: waddr, ds: 2'b11, din: 16'h0};
    qm.push_back(t);
  endtask

  // Memory model: answers each request toggle LAT+1 cycles later.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic        m_req = 1'b0, m_we = 1'b0;
  logic [21:0] m_addr = '0;
  logic [1:0]  m_ds = '0;
  logic [15:0] m_din = '0;
  always @(negedge clk_sys) begin
    if (m_busy) begin
      if (m_cnt == 0) begin
        if (m_we) begin
          if (m_ds[1]) mem[m_addr[7:0]][15:8] = m_din[15:8];
          if (m_ds[0]) mem[m_addr[7:0]][7:0]  = m_din[7:0];
        end else begin
          mem_dout = mem[m_addr[7:0]];
        end
        mem_ack = m_req;
        m_busy  = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (mem_req !== mem_ack) begin
      m_busy = 1'b1;
      m_cnt  = LAT;
      m_req  = mem_req;
      m_we   = mem_we;
      m_addr = mem_addr;
      m_ds   = mem_ds;
      m_din  = mem_din;
    end
  end

  // Memory-side scoreboard: every request toggle must match the next entry.
  logic prev_req = 1'b0;
  always @(negedge clk_sys) begin
    if (!reset && mem_req !== prev_req) begin
      n_tog++;
      if (qm.size() == 0) begin
        chk("mem_unexpected_toggle", {9'b0, mem_we, mem_addr}, 32'h0);
      end else begin
        mtx_t e;
        e = qm.pop_front();
        chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
        chk("mem_addr", {10'b0, mem_addr}, {10'b0, e.addr});
        chk("mem_ds", {30'b0, mem_ds}, {30'b0, e.ds});
        if (e.we) chk("mem_din", {16'b0, mem_din}, {16'b0, e.din});
      end
    end
    prev_req = mem_req;
  end

  // Read-data scoreboard: each valid cycle consumes exactly one expectation.
  always @(negedge clk_sys) begin
    if (!reset && a_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_valid_unexpected", {24'b0, a_data}, 32'hFFFF);
      else                chk("a_data", {24'b0, a_data}, {24'b0, qa.pop_front()});
    end
    if (!reset && b_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_valid_unexpected", {24'b0, b_data}, 32'hFFFF);
      else                chk("b_data", {24'b0, b_data}, {24'b0, qb.pop_front()});
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_req"}, {31'b0, mem_req}, 32'h0);
    chk({pfx, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    chk({pfx, "_mem_addr"}, {10'b0, mem_addr}, 32'h0);
    chk({pfx, "_mem_ds"}, {30'b0, mem_ds}, 32'h0);
    chk({pfx, "_mem_din"}, {16'b0, mem_din}, 32'h0);
    chk({pfx, "_a_data"}, {24'b0, a_data}, 32'h0);
    chk({pfx, "_b_data"}, {24'b0, b_data}, 32'h0);
    chk({pfx, "_a_valid"}, {31'b0, a_valid}, 32'h0);
    chk({pfx, "_b_valid"}, {31'b0, b_valid}, 32'h0);
    chk({pfx, "_dl_ovf"}, {31'b0, dl_ovf}, 32'h0);
  endtask

  initial begin
    mtx_t t;
    int   exp_tog;
    for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h5A, 8'(i)};
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;

    // Reset state.
    #2 reset = 1'b1;
    tick(2);
    chk_zero("rst");
    reset = 1'b0;
    tick(2);

    // Download byte 0x000005 = 0xA5; a read strobe during download is dropped.
    ioctl_downl = 1'b1;
    tick();
    t = '{we: 1'b1, addr: 22'h000002, ds: 2'b10, din: 16'hA5A5};
    qm.push_back(t);
    ioctl_addr = 25'h000005; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
    a_rd = 1'b1; a_addr = 16'h0040;
    tick();
    ioctl_wr = 1'b0; a_rd = 1'b0;
    tick(15);
    chk("dl_toggles", n_tog, 1);
    ioctl_downl = 1'b0;
    tick(2);

    // Simultaneous A and B reads: A first after reset.
    push_rd(22'h0); push_rd(22'h1);
    qa.push_back(8'h12); qb.push_back(8'h78);
    a_rd = 1'b1; a_addr = 16'h0001; b_rd = 1'b1; b_addr = 16'h0002;
    tick();
    a_rd = 1'b0; b_rd = 1'b0;
    tick(30);

    // Two download strobes while a read is outstanding: overrun, first kept.
    push_rd(22'h2);
    t = '{we: 1'b1, addr: 22'h000080, ds: 2'b01, din: 16'h1111};
    qm.push_back(t);
    qa.push_back(8'hA5);
    a_rd = 1'b1; a_addr = 16'h0005;
    tick();
    a_rd = 1'b0;
    tick();
    ioctl_addr = 25'h000100; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    ioctl_addr = 25'h000101; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("dl_ovf_set", {31'b0, dl_ovf}, 32'h1);
    tick(30);
    chk("dl_ovf_sticky", {31'b0, dl_ovf}, 32'h1);

    // Reset during RD_WAIT: outputs clear at once, late ack is ignored.
    push_rd(22'h1);
    a_rd = 1'b1; a_addr = 16'h0003;
    tick();
    a_rd = 1'b0;
    tick(2);
    #2 reset = 1'b1;
    #1 chk_zero("rst_rdwait");
    tick(2);
    reset = 1'b0;
    tick(30);

    // Same-word re-read: served from cache when built in, else from memory.
    push_rd(22'h8);
`ifndef ROM_WORD_CACHE_EN
    push_rd(22'h8);
`endif
    qa.push_back(8'h08); qa.push_back(8'h52);
    a_rd = 1'b1; a_addr = 16'h0010;
    tick();
    a_rd = 1'b0;
    tick(15);
    a_rd = 1'b1; a_addr = 16'h0011;
    tick();
    a_rd = 1'b0;
`ifdef ROM_WORD_CACHE_EN
    chk("cache_hit_valid", {31'b0, a_valid}, 32'h1);
`else
    chk("nocache_no_early_valid", {31'b0, a_valid}, 32'h0);
`endif
    tick(15);

    // Both pending again: B wins since A was served last.
    push_rd(22'h3); push_rd(22'h2);
    qb.push_back(8'h59); qa.push_back(8'h02);
    a_rd = 1'b1; a_addr = 16'h0004; b_rd = 1'b1; b_addr = 16'h0007;
    tick();
    a_rd = 1'b0; b_rd = 1'b0;
    tick(30);

    // Coalescing: two A strobes while B is in flight give one response.
    push_rd(22'h1); push_rd(22'h4);
    qb.push_back(8'h78); qa.push_back(8'h04);
    b_rd = 1'b1; b_addr = 16'h0002;
    tick();
    b_rd = 1'b0;
    tick();
    a_rd = 1'b1; a_addr = 16'h0009;
    tick();
    a_addr = 16'h0008;
    tick();
    a_rd = 1'b0;
    tick(30);

    // Everything expected must have been seen.
`ifdef ROM_WORD_CACHE_EN
    exp_tog = 11;
`else
    exp_tog = 12;
`endif
    chk("total_toggles", n_tog, exp_tog);
    chk("qm_drained", qm.size(), 0);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("dl_ovf_final", {31'b0, dl_ovf}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter: RD_AW, 16, byte-address width of each read requester.
REQ-002 SHALL have ports: clk_sys  in  1  system clock (48 MHz); all logic on its rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: ioctl_downl in 1 download active; ioctl_wr in 1 download byte strobe; ioctl_addr in 25 byte address; ioctl_dout in 8 byte data.
REQ-005 SHALL have ports: a_rd in 1 read strobe; a_addr in RD_AW byte address; a_data out 8; a_valid out 1 one-cycle data strobe (requester A, main CPU).
REQ-006 SHALL have ports: b_rd, b_addr, b_data, b_valid, identical to A (requester B, second CPU).
REQ-007 SHALL have ports: mem_req out 1 toggle request; mem_ack in 1 toggle acknowledge; mem_we out 1; mem_addr out 22 word address; mem_ds out 2 byte enables; mem_din out 16; mem_dout in 16.
REQ-008 SHALL have port: dl_ovf out 1 sticky download-overrun flag.

Function
REQ-009 SHALL implement FSM states IDLE, DL_WAIT, RD_WAIT; one memory transaction outstanding at most.
REQ-010 SHALL latch ioctl_wr rising edges into dl_pend, a_rd into a_pend (with a_addr), b_rd into b_pend (with b_addr).
REQ-011 SHALL, in IDLE with any pending flag, toggle mem_req and drive mem_addr/mem_ds/mem_we/mem_din on the same edge, entering DL_WAIT or RD_WAIT.
REQ-012 SHALL give priority: dl_pend first; then A/B round-robin, the requester not served last winning when both pend; A wins first after reset.
REQ-013 SHALL, for download writes, drive mem_we=1, mem_addr=ioctl_addr[22:1], mem_ds={ioctl_addr[0],~ioctl_addr[0]}, mem_din={ioctl_dout,ioctl_dout}.
REQ-014 SHALL, for reads, drive mem_we=0, mem_ds=2'b11, mem_addr=zero-extended addr[RD_AW-1:1].
REQ-015 SHALL complete a transaction on the first cycle mem_ack==mem_req; return to IDLE next edge.
REQ-016 SHALL, on read completion, register x_data=mem_dout[15:8] if addr[0]=1 else [7:0], and pulse x_valid for exactly one cycle together.
REQ-017 SHALL coalesce a new x_rd arriving while x_pend is set and unserved: address replaced, single response.
REQ-018 SHALL treat x_rd arriving while x's read is in RD_WAIT as a new pending read, served after completion.
REQ-019 SHALL set dl_ovf when ioctl_wr rises while dl_pend is already set; cleared only by reset.
REQ-020 SHALL ignore and drop a_rd/b_rd while ioctl_downl=1; pending reads cleared on ioctl_downl rising edge; no x_valid issued for them.
REQ-021 SHALL clear dl_pend on download transaction start; download completion produces no x_valid.

Reset
REQ-022 SHALL, on reset asserted, immediately force: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_ds=0, mem_din=0, a_data=b_data=0, a_valid=b_valid=0, dl_ovf=0, all pend flags 0, round-robin pointer to A.
REQ-023 SHALL abandon any outstanding transaction on reset; mem_ack returning later is ignored until next request (mem_req compared afresh, reset side guaranteeing mem_ack=0).

Configuration
REQ-024 SHALL, with ROM_WORD_CACHE_EN defined, hold per requester one cached word (tag addr[RD_AW-1:1], data, valid bit).
REQ-025 SHALL, with ROM_WORD_CACHE_EN, answer x_rd hitting a valid tag with x_valid and correct byte on the next edge, no mem_req toggle; miss fills the cache on completion.
REQ-026 SHALL, with ROM_WORD_CACHE_EN, invalidate both caches on reset and on ioctl_downl rising edge.
REQ-027 SHALL, without ROM_WORD_CACHE_EN, send every read to memory; no cache storage synthesised.

Verification
REQ-028 SHALL cover: download byte addr 0x000005 data 0xA5 -> mem_we=1, mem_addr=0x000002, mem_ds=2'b10, mem_din=0xA5A5, one mem_req toggle.
REQ-029 SHALL cover: a_rd and b_rd same cycle, addr 0x0001/0x0002, mem_dout 0x1234 then 0x5678 -> A served first, a_data=0x12, then b_data=0x78, each one-cycle valid.
REQ-030 SHALL cover: two ioctl_wr rises while a read waits in RD_WAIT -> dl_ovf=1, first write still issued after read completes.
REQ-031 SHALL cover: reset asserted in RD_WAIT -> all outputs zero same cycle, late mem_ack produces no a_valid.
REQ-032 SHALL cover (cache build): a_rd 0x0010 then 0x0011 -> one mem_req toggle, second a_valid one cycle after strobe, data = high byte of same word.
REQ-033 SHALL cover: a_rd during ioctl_downl=1 -> no mem_req toggle, no a_valid.
